// File: rtl/shift_cmd_sequencer_if.sv
// Command / result handshake bundle for shift_cmd_sequencer.
// master: the command producer and result consumer; slave: the sequencer.
interface shift_cmd_sequencer_if #(
  parameter int DW = 8,
  parameter int SW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_shamt;
  logic          cmd_dir;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_shamt, cmd_dir, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_shamt, cmd_dir, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Upstream feeder for the barrel shifter: buffers rotate commands in a FIFO,
// drives the shifter load/shift/capture sequence one command at a time and
// presents each captured result on a valid/ready port.
// Optional build macro SHIFT_SEQ_SELFCHECK_EN adds a reference rotate model
// that flags a mismatching shifter output on the sticky chk_err output.
module shift_cmd_sequencer #(
  parameter int DW         = 8,
  parameter int SW         = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SHIFT_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  shift_cmd_sequencer_if.slave          bus,
  output logic [DW-1:0]                 sh_i,
  output logic [SW-1:0]                 sh_s,
  output logic [1:0]                    sh_c,
  input  logic [DW-1:0]                 sh_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          chk_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;
  localparam int EW = DW + SW + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [2:0]    state_q, state_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wshamt_q, wshamt_d;
  logic          wdir_q, wdir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          push, pop, full, empty;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  // cmd_ready depends only on registered occupancy, never on a same-cycle pop
  assign push  = bus.cmd_valid && !full;

  // FIFO storage: payload only, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_dir, bus.cmd_shamt, bus.cmd_data};
  end

  // FIFO pointer and occupancy update; pointers wrap at the power-of-2 depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Sequencer: pop a command, load, optional shift, wait SHIFT_LAT, hold result
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    wshamt_d    = wshamt_q;
    wdir_d      = wdir_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = (wshamt_q == '0) ? S_CAPT : S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d   = '0;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        if (cnt_q == CW'(SHIFT_LAT - 1)) begin
          res_data_d  = sh_o;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) {wdir_d, wshamt_d, wdata_d} = mem_q[rd_ptr_q];
  end

  // Control and working registers; reset drops in-flight and queued commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      wdata_q     <= '0;
      wshamt_q    <= '0;
      wdir_q      <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      wdata_q     <= wdata_d;
      wshamt_q    <= wshamt_d;
      wdir_q      <= wdir_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Shifter control decode from the current state
  always_comb begin
    sh_c = 2'b00;
    case (state_q)
      S_LOAD:  sh_c = 2'b11;
      S_SHIFT: sh_c = wdir_q ? 2'b10 : 2'b01;
      default: sh_c = 2'b00;
    endcase
  end

  assign sh_i          = wdata_q;
  assign sh_s          = wshamt_q;
  assign busy          = (state_q != S_IDLE);
  assign fifo_level    = level_q;
  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

`ifdef SHIFT_SEQ_SELFCHECK_EN
  logic chk_err_q, chk_err_d;

  function automatic logic [DW-1:0] rot_ref(input logic [DW-1:0] d,
                                            input logic [SW-1:0] s,
                                            input logic          left);
    logic [2*DW-1:0] t;
    t = left ? ({d, d} << s) : ({d, d} >> s);
    return left ? t[2*DW-1:DW] : t[DW-1:0];
  endfunction

  // Compare the shifter output with the reference rotate on the capture edge
  always_comb begin
    chk_err_d = chk_err_q;
    if (state_q == S_CAPT && cnt_q == CW'(SHIFT_LAT - 1) &&
        sh_o != rot_ref(wdata_q, wshamt_q, wdir_q))
      chk_err_d = 1'b1;
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer with a registered 8-bit rotate shifter stub.
`timescale 1ns/1ps
module tb_shift_cmd_sequencer;
  localparam int DW = 8;
  localparam int SW = 3;
  localparam int FD = 4;
`ifdef SHIFT_SEQ_SELFCHECK_EN
  localparam bit SELFCHK = 1'b1;
`else
  localparam bit SELFCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sh_i, sh_o, sh_reg;
  logic [SW-1:0] sh_s;
  logic [1:0]    sh_c;
  logic          busy, chk_err;
  logic [2:0]    fifo_level;
  bit            force_zero = 1'b0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [1:0]    seq [16];

  shift_cmd_sequencer_if #(.DW(DW), .SW(SW)) sif ();

  shift_cmd_sequencer #(.DW(DW), .SW(SW), .FIFO_DEPTH(FD), .SHIFT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave),
    .sh_i(sh_i), .sh_s(sh_s), .sh_c(sh_c), .sh_o(sh_o),
    .busy(busy), .fifo_level(fifo_level), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Rotate expressed with plain arithmetic: left = d*2^s mod 256 + d/2^(8-s)
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s, input bit left);
    int v, p;
    v = int'(d);
    p = 1 << s;
    if (left) return 8'((v * p) % 256 + v / (256 / p));
    return 8'(v / p + (v * (256 / p)) % 256);
  endfunction

  // Shifter stub: registered output, 11 load, 01 rotr, 10 rotl, 00 hold
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_reg <= '0;
    else case (sh_c)
      2'b11:   sh_reg <= sh_i;
      2'b01:   sh_reg <= ref_rot(sh_reg, int'(sh_s), 1'b0);
      2'b10:   sh_reg <= ref_rot(sh_reg, int'(sh_s), 1'b1);
      default: sh_reg <= sh_reg;
    endcase
  end
  assign sh_o = force_zero ? 8'h00 : sh_reg;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] s, input bit dir, output bit acc);
    sif.cmd_valid = 1'b1;
    sif.cmd_data  = d;
    sif.cmd_shamt = s;
    sif.cmd_dir   = dir;
    acc = sif.cmd_ready;
    if (acc) exp_q.push_back(ref_rot(d, int'(s), dir));
    step();
    sif.cmd_valid = 1'b0;
  endtask

  // Steps until res_valid (bounded); seq[n] holds sh_c after the n-th edge
  task automatic wait_valid(output int n);
    n = 0;
    while (!sif.res_valid && n < 64) begin
      step();
      n++;
      if (n < 16) seq[n] = sh_c;
    end
  endtask

  task automatic ack();
    sif.res_ready = 1'b1;
    step();
    sif.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit acc;
    int n;
    checks++;
    if ({sif.cmd_ready, sif.res_valid, busy, chk_err, sh_c, fifo_level} !== 9'b1_0_0_0_00_000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required %b",
               {sif.cmd_ready, sif.res_valid, busy, chk_err, sh_c, fifo_level}, 9'b100000000);
    end
    checks++;
    if ({sif.res_data, sh_i, sh_s} !== '0) begin
      errors++;
      $display("FAIL reset_data: res_data %h sh_i %h sh_s %0d required 0", sif.res_data, sh_i, sh_s);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send(8'(i * 37 + 5), 3'(i + 1), i[0], acc);
    wait_valid(n);
    checks++;
    if (!sif.res_valid || fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL hold_queued: res_valid %b fifo_level %0d required 1 and 3", sif.res_valid, fifo_level);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({sif.res_valid, fifo_level, sh_c, sif.cmd_ready, busy} !== 8'b0_000_00_1_0) begin
      errors++;
      $display("FAIL mid_reset: res_valid/level/sh_c/cmd_ready/busy got %b required %b",
               {sif.res_valid, fifo_level, sh_c, sif.cmd_ready, busy}, 8'b00000010);
    end
    exp_q.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (busy !== 1'b0 || sif.res_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_drop: busy %b res_valid %b level %0d required 0 0 0", busy, sif.res_valid, fifo_level);
    end
  endtask

  task automatic test_rotate_left();
    bit acc;
    int n;
    logic [7:0] e;
    send(8'b11100111, 3'd2, 1'b1, acc);
    wait_valid(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rotl_latency: got %0d edges required 4", n); end
    checks++;
    if ({seq[1], seq[2], seq[3]} !== 6'b11_10_00) begin
      errors++;
      $display("FAIL rotl_sh_c: got %b %b %b required 11 10 00", seq[1], seq[2], seq[3]);
    end
    checks++;
    if (sif.res_data !== 8'b10011111) begin
      errors++;
      $display("FAIL rotl_data: got %b required 10011111", sif.res_data);
    end
    e = exp_q.pop_front();
    ack();
    checks++;
    if (chk_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rotl_after: chk_err %b busy %b required 0 0 (model %h)", chk_err, busy, e);
    end
  endtask

  task automatic test_rotate_right();
    bit acc;
    int n;
    logic [7:0] e;
    send(8'b00011010, 3'd1, 1'b0, acc);
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (sif.res_data !== 8'b00001101 || e !== 8'b00001101) begin
      errors++;
      $display("FAIL rotr_data: got %b model %b required 00001101", sif.res_data, e);
    end
    ack();
    send(8'b01010101, 3'd3, 1'b1, acc);
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (sif.res_data !== 8'b10101010) begin
      errors++;
      $display("FAIL rotl3_data: got %b required 10101010", sif.res_data);
    end
    ack();
  endtask

  task automatic test_zero_shift();
    bit acc;
    int n;
    logic [7:0] e;
    send(8'b11001100, 3'd0, 1'b0, acc);
    wait_valid(n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL zero_latency: got %0d edges required 3", n); end
    checks++;
    if ({seq[1], seq[2]} !== 4'b11_00) begin
      errors++;
      $display("FAIL zero_sh_c: got %b %b required 11 00", seq[1], seq[2]);
    end
    e = exp_q.pop_front();
    checks++;
    if (sif.res_data !== 8'b11001100) begin
      errors++;
      $display("FAIL zero_data: got %b required 11001100 (model %b)", sif.res_data, e);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n, acc_cnt;
    logic [7:0] held, e;
    send(8'($urandom), 3'($urandom), 1'($urandom), acc);
    wait_valid(n);
    held = sif.res_data;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 3'($urandom), 1'($urandom), acc);
      acc_cnt += int'(acc);
    end
    checks++;
    if (acc_cnt !== 4 || fifo_level !== 3'd4 || sif.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: accepted %0d level %0d cmd_ready %b required 4 4 0", acc_cnt, fifo_level, sif.cmd_ready);
    end
    checks++;
    if (sif.res_valid !== 1'b1 || sif.res_data !== held) begin
      errors++;
      $display("FAIL held: res_valid %b res_data %h required 1 %h", sif.res_valid, sif.res_data, held);
    end
    sif.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(n);
      e = exp_q.pop_front();
      checks++;
      if (n >= 64 || sif.res_data !== e) begin
        errors++;
        $display("FAIL drain%0d: res_data %h required %h (wait %0d)", i, sif.res_data, e, n);
      end
      step();
      if (i < 4) begin
        checks++;
        if (sh_c !== 2'b11 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b%0d: sh_c %b busy %b required 11 1", i, sh_c, busy);
        end
      end
    end
    sif.res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL drain_idle: busy %b level %0d required 0 0", busy, fifo_level);
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc = 0;
    logic [7:0] e;
    while ((sent < 40 || exp_q.size() > 0) && cyc < 3000) begin
      if (sent < 40 && $urandom_range(0, 2) != 0) begin
        sif.cmd_valid = 1'b1;
        sif.cmd_data  = 8'($urandom);
        sif.cmd_shamt = 3'($urandom);
        sif.cmd_dir   = 1'($urandom);
      end else begin
        sif.cmd_valid = 1'b0;
      end
      sif.res_ready = ($urandom_range(0, 1) == 1);
      if (sif.cmd_valid && sif.cmd_ready) begin
        exp_q.push_back(ref_rot(sif.cmd_data, int'(sif.cmd_shamt), sif.cmd_dir));
        sent++;
      end
      if (sif.res_valid && sif.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: unexpected result %h", sif.res_data);
        end else begin
          e = exp_q.pop_front();
          if (sif.res_data !== e) begin
            errors++;
            $display("FAIL rand_data: got %h required %h", sif.res_data, e);
          end
        end
      end
      checks++;
      if (sif.cmd_ready !== (fifo_level != 3'd4) || fifo_level > 3'd4) begin
        errors++;
        $display("FAIL rand_level: cmd_ready %b level %0d", sif.cmd_ready, fifo_level);
      end
      step();
      cyc++;
    end
    sif.cmd_valid = 1'b0;
    sif.res_ready = 1'b0;
    checks++;
    if (cyc >= 3000 || chk_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_end: cycles %0d chk_err %b pending %0d", cyc, chk_err, exp_q.size());
    end
  endtask

  task automatic test_selfcheck();
    bit acc;
    int n;
    logic [7:0] e;
    force_zero = 1'b1;
    send(8'hA5, 3'd3, 1'b1, acc);
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (sif.res_data !== 8'h00 || chk_err !== SELFCHK) begin
      errors++;
      $display("FAIL selfcheck_bad: res_data %h chk_err %b required 00 %b (true %h)", sif.res_data, chk_err, SELFCHK, e);
    end
    ack();
    force_zero = 1'b0;
    send(8'h3C, 3'd5, 1'b0, acc);
    wait_valid(n);
    e = exp_q.pop_front();
    checks++;
    if (sif.res_data !== e || chk_err !== SELFCHK) begin
      errors++;
      $display("FAIL selfcheck_sticky: res_data %h chk_err %b required %h %b", sif.res_data, chk_err, e, SELFCHK);
    end
    ack();
  endtask

  initial begin
    sif.cmd_valid = 1'b0;
    sif.cmd_data  = '0;
    sif.cmd_shamt = '0;
    sif.cmd_dir   = 1'b0;
    sif.res_ready = 1'b0;
    #12;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_zero_shift();
    test_back_to_back();
    test_random();
    test_selfcheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Upstream feeder for the 8-bit barrel shifter.
- Accepts rotate commands over a valid/ready interface and buffers them in a small FIFO.
- For each command it drives the shifter's load-then-shift control sequence, captures the shifter output and presents it on a valid/ready result port.
- One command is in flight at a time; the FIFO absorbs bursts.

Parameters:
- DW, 8, data width; must match the shifter.
- SW, 3, shift-amount width; must equal log2(DW).
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2 and at least 2.
- SHIFT_LAT, 1, cycles from the shift control cycle to sh_o being stable; 1 to 3.

Ports:
- clk, in, 1, system clock; rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, FIFO can accept a command.
- cmd_data, in, DW, operand.
- cmd_shamt, in, SW, rotate amount.
- cmd_dir, in, 1, rotate direction: 0 = rotate right, 1 = rotate left.
- sh_i, out, DW, shifter data input.
- sh_s, out, SW, shifter amount input.
- sh_c, out, 2, shifter control: 11 = load, 01 = rotate right, 10 = rotate left, 00 = hold.
- sh_o, in, DW, shifter registered output.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts the result.
- res_data, out, DW, captured result.
- busy, out, 1, FSM is not in IDLE.
- fifo_level, out, log2(FIFO_DEPTH)+1, FIFO occupancy.
- chk_err, out, 1, self-check error; sticky.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - cmd_ready = 1; res_valid = 0; res_data = 0.
  - sh_i = 0; sh_s = 0; sh_c = 00.
  - busy = 0; fifo_level = 0; chk_err = 0.
  - FIFO pointers cleared; FSM in IDLE.
  - Reset asserted mid-operation drops the in-flight command and all queued commands.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !full. It is not combinationally relieved by a same-cycle pop.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - cmd_valid while full is ignored and no data is written.
- FSM states: IDLE, LOAD, SHIFT, CAPT, HOLD.
  - IDLE: if the FIFO is not empty, pop the head into working registers and go to LOAD. Otherwise stay; sh_c = 00.
  - LOAD (1 cycle): sh_c = 11; sh_i = data; sh_s = shamt. Go to SHIFT, or to CAPT when shamt == 0.
  - SHIFT (1 cycle): sh_c = 01 if dir = 0, 10 if dir = 1; sh_s = shamt.
  - CAPT: sh_c = 00; count SHIFT_LAT cycles. On the final cycle, register sh_o into res_data, set res_valid and go to HOLD.
  - HOLD: res_valid = 1 and res_data stable until res_ready. On the handshake clear res_valid, then go to LOAD with an immediate pop if the FIFO is not empty, else to IDLE.
- Latency: with an idle FSM and empty FIFO, res_valid rises on the 4th rising edge after the accepting edge (SHIFT_LAT = 1, shamt != 0). It rises on the 3rd edge when shamt == 0.
- res_ready asserted while res_valid = 0 has no effect.
- Results are returned in command order.

Optional Feature:
- Macro: SHIFT_SEQ_SELFCHECK_EN.
- Defined: an internal reference model computes the expected rotate of data by shamt in direction dir. On the capture edge, a mismatch with sh_o sets chk_err. chk_err stays set until rst_n.
- Undefined: no reference logic is built; chk_err is tied to 0.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-HOLD with 3 commands queued. Required: res_valid = 0, fifo_level = 0, sh_c = 00, cmd_ready = 1, busy = 0.
- Single rotate-left: cmd 11100111, shamt 2, dir 1. Required: sh_c sequence 11, 10, 00; res_data = 10011111; res_valid on the 4th edge after accept.
- Single rotate-right: cmd 00011010, shamt 1, dir 0. Required: res_data = 00001101. Then cmd 01010101, shamt 3, dir 1. Required: res_data = 10101010.
- Zero shift: cmd 11001100, shamt 0. Required: no SHIFT cycle (sh_c goes 11 then 00); res_data = 11001100; res_valid on the 3rd edge.
- Backpressure/full: hold res_ready = 0 and push 6 commands. Required: 4 accepted, cmd_ready = 0, fifo_level = 4, and res_data held. Then release res_ready. Required: results drain in order, back-to-back HOLD to LOAD with no IDLE cycle.
- Self-check (macro defined): force the shifter stub to return 8'h00 for one command. Required: chk_err = 1, and it stays 1 after subsequent correct results.
